rv_regfile_sb: RTL and testbench

// - Parametrised integer register file with scoreboard; replaces the single-cycle core's fixed 2R/1W regfile.
// - Sits between id_stage (source reads, destination issue) and the writeback path.
// - Tracks in-flight destination registers and gives ID per-source busy flags plus an issue handshake for stall logic.

---
 rtl/rv_regfile_sb_pkg.sv | 29 ++
 rtl/rv_regfile_sb_if.sv | 54 +++++
 rtl/rv_regfile_sb_scoreboard.sv | 92 +++++++++
 rtl/rv_regfile_sb.sv | 81 ++++++++
 tb/tb_rv_regfile_sb.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// rv_regfile_sb_pkg
// Shared configuration and types for the scoreboarded integer register file.
// Holds the default geometry (data width, register count, read-port count),
// the derived address/count widths, and the request/writeback bundle types
// that ID and the writeback path use when talking to the register file.
// ---------------------------------------------------------------------------
package rv_regfile_sb_pkg;

  localparam int RF_XLEN  = 64;
  localparam int RF_NREGS = 32;
  localparam int RF_NRD   = 2;
  localparam int RF_AW    = $clog2(RF_NREGS);
  localparam int RF_CW    = $clog2(RF_NREGS + 1);

  typedef logic [RF_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
  } rf_rd_req_t;

  typedef struct packed {
    logic               valid;
    reg_addr_t          addr;
    logic [RF_XLEN-1:0] data;
  } rf_wb_packet_t;

endpackage

// File: rtl/rv_regfile_sb_if.sv
// ---------------------------------------------------------------------------
// rv_regfile_sb_if
// Bundles every non-clock signal between the core (ID + writeback) and the
// register file.
//   rd_en/rd_addr        source read requests, one per read port
//   rd_data/rd_busy      read data and pending-producer flag per port
//   iss_valid/iss_rd_addr/iss_ready   destination issue handshake
//   wb_valid/wb_addr/wb_data          writeback strobe
//   flush                squash all pending producers
//   busy_cnt             registered count of busy registers
//   err_wb_idle          sticky flag: writeback to a non-busy register
// Modports: master = core side, slave = register file side.
// ---------------------------------------------------------------------------
interface rv_regfile_sb_if
  import rv_regfile_sb_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = RF_NRD
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NRD-1:0]           rd_en;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;

  logic                     iss_valid;
  logic [AW-1:0]            iss_rd_addr;
  logic                     iss_ready;

  logic                     wb_valid;
  logic [AW-1:0]            wb_addr;
  logic [XLEN-1:0]          wb_data;

  logic                     flush;
  logic [CW-1:0]            busy_cnt;
  logic                     err_wb_idle;

  modport master (
    output rd_en, rd_addr, iss_valid, iss_rd_addr,
           wb_valid, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, iss_ready, busy_cnt, err_wb_idle
  );

  modport slave (
    input  rd_en, rd_addr, iss_valid, iss_rd_addr,
           wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_busy, iss_ready, busy_cnt, err_wb_idle
  );

endinterface

// File: rtl/rv_regfile_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Tracks which architectural registers have an in-flight producer.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   iss_valid_i      ID is issuing an instruction with a destination
//   iss_rd_addr_i    destination being issued
//   iss_ready_o      issue can be accepted (no WAW hazard)
//   wb_valid_i       writeback strobe
//   wb_addr_i        writeback destination
//   flush_i          clear all busy bits
//   busy_o           current busy vector (bit 0 always 0)
//   busy_cnt_o       registered popcount of the busy vector
//   err_wb_idle_o    sticky: a writeback hit a register that was not busy
// ---------------------------------------------------------------------------
module rf_scoreboard
  import rv_regfile_sb_pkg::*;
#(
  parameter int NREGS = RF_NREGS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iss_valid_i,
  input  logic [$clog2(NREGS)-1:0]      iss_rd_addr_i,
  output logic                          iss_ready_o,
  input  logic                          wb_valid_i,
  input  logic [$clog2(NREGS)-1:0]      wb_addr_i,
  input  logic                          flush_i,
  output logic [NREGS-1:0]              busy_o,
  output logic [$clog2(NREGS+1)-1:0]    busy_cnt_o,
  output logic                          err_wb_idle_o
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q;
  logic             err_q, err_d;
  logic             wb_hit;
  logic             iss_acc;

  function automatic logic [CW-1:0] popcnt(input logic [NREGS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // A same-cycle writeback to the issued destination frees the slot, so the
  // issue may proceed; x0 never has a producer to wait on.
  always_comb begin
    wb_hit      = wb_valid_i && (wb_addr_i != '0);
    iss_ready_o = (iss_rd_addr_i == '0) || !busy_q[iss_rd_addr_i] ||
                  (wb_valid_i && (wb_addr_i == iss_rd_addr_i));
    iss_acc     = iss_valid_i && iss_ready_o && (iss_rd_addr_i != AW'(0)) && !flush_i;

    // Clear before set so an issue to the register being written back wins;
    // flush overrides both.
    busy_d = busy_q;
    if (wb_hit) begin
      busy_d[wb_addr_i] = 1'b0;
    end
    if (iss_acc) begin
      busy_d[iss_rd_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end

    err_d = err_q || (wb_hit && !busy_q[wb_addr_i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= popcnt(busy_d);
      err_q  <= err_d;
    end
  end

  assign busy_o        = busy_q;
  assign busy_cnt_o    = cnt_q;
  assign err_wb_idle_o = err_q;

endmodule

// File: rtl/rv_regfile_sb.sv
// ---------------------------------------------------------------------------
// rv_regfile_sb
// Parametrised integer register file with a producer scoreboard. Provides
// NRD combinational read ports with per-port busy flags, one write port from
// writeback, and an issue handshake that blocks WAW hazards. x0 reads as zero
// and is never written or marked busy.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   rf_if      rv_regfile_sb_if.slave (read ports, issue, writeback, flush,
//              busy_cnt, err_wb_idle)
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a read of the register being written
//                      back this cycle returns wb_data and reports not busy.
//                      Otherwise the stored value is returned and the port
//                      stays busy until the write lands.
// ---------------------------------------------------------------------------
module rv_regfile_sb
  import rv_regfile_sb_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = RF_NRD
) (
  input  logic          clk,
  input  logic          rst,
  rv_regfile_sb_if.slave rf_if
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_en;

  assign wr_en = rf_if.wb_valid && (rf_if.wb_addr != '0);

  // Register storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rf_if.wb_addr] <= rf_if.wb_data;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .iss_valid_i   (rf_if.iss_valid),
    .iss_rd_addr_i (rf_if.iss_rd_addr),
    .iss_ready_o   (rf_if.iss_ready),
    .wb_valid_i    (rf_if.wb_valid),
    .wb_addr_i     (rf_if.wb_addr),
    .flush_i       (rf_if.flush),
    .busy_o        (busy),
    .busy_cnt_o    (rf_if.busy_cnt),
    .err_wb_idle_o (rf_if.err_wb_idle)
  );

  // Read ports see the pre-edge busy state, so a same-cycle issue to the
  // source is not yet visible here.
  always_comb begin
    rf_if.rd_data = '0;
    rf_if.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rf_if.rd_en[i] && (rf_if.rd_addr[i] != '0)) begin
        rf_if.rd_data[i] = regs_q[rf_if.rd_addr[i]];
        rf_if.rd_busy[i] = busy[rf_if.rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (rf_if.wb_addr == rf_if.rd_addr[i])) begin
          rf_if.rd_data[i] = rf_if.wb_data;
          rf_if.rd_busy[i] = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_rv_regfile_sb
// Directed bench for the scoreboarded register file. Inputs change 1ns after
// the rising edge, combinational outputs are checked 1ns later, and
// registered outputs are checked after the following edge.
// ---------------------------------------------------------------------------
module tb_rv_regfile_sb;
  import rv_regfile_sb_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  rv_regfile_sb_if #(.XLEN(64), .NREGS(32), .NRD(2)) rfIf ();

  rv_regfile_sb #(
    .XLEN  (64),
    .NREGS (32),
    .NRD   (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rf_if (rfIf.slave)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set up one read port; takes effect with the next applyStimulus.
  task automatic setRead(input int p, input logic en, input int a);
    rfIf.rd_en[p]   = en;
    rfIf.rd_addr[p] = 5'(a);
  endtask

  // Drive issue/writeback/flush for this cycle and let combinational logic settle.
  task automatic applyStimulus(input logic iv, input int ia, input logic wv,
                               input int wa, input logic [63:0] wd, input logic fl);
    rfIf.iss_valid   = iv;
    rfIf.iss_rd_addr = 5'(ia);
    rfIf.wb_valid    = wv;
    rfIf.wb_addr     = 5'(wa);
    rfIf.wb_data     = wd;
    rfIf.flush       = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 1'b0, 0, 64'h0, 1'b0);
  endtask

  // Compare one observed value against the bench's expected value.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Directed sequence: reset, issue/writeback, WAW, x0, idle writeback,
  // flush, bypass behaviour, and asynchronous reset mid-operation.
  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1;
    rfIf.rd_en = '0;
    rfIf.rd_addr = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    setRead(0, 1'b1, 5);
    setRead(1, 1'b1, 0);
    idle();
    checkOutput("rst_busy_cnt", 64'(rfIf.busy_cnt), 64'd0);
    checkOutput("rst_err", 64'(rfIf.err_wb_idle), 64'd0);
    checkOutput("rst_rd0_data", rfIf.rd_data[0], 64'd0);
    checkOutput("rst_rd0_busy", 64'(rfIf.rd_busy[0]), 64'd0);
    checkOutput("rst_rd1_data", rfIf.rd_data[1], 64'd0);

    // Issue x5; same-cycle read sees pre-issue state
    applyStimulus(1'b1, 5, 1'b0, 0, 64'h0, 1'b0);
    checkOutput("x5_iss_ready", 64'(rfIf.iss_ready), 64'd1);
    checkOutput("x5_preissue_busy", 64'(rfIf.rd_busy[0]), 64'd0);
    tick();
    idle();
    checkOutput("x5_busy_cnt1", 64'(rfIf.busy_cnt), 64'd1);
    checkOutput("x5_busy_c1", 64'(rfIf.rd_busy[0]), 64'd1);
    tick();
    idle();
    checkOutput("x5_busy_c2", 64'(rfIf.rd_busy[0]), 64'd1);
    tick();
    applyStimulus(1'b0, 0, 1'b1, 5, 64'hDEAD_BEEF, 1'b0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("x5_wbcyc_data", rfIf.rd_data[0], 64'hDEAD_BEEF);
    checkOutput("x5_wbcyc_busy", 64'(rfIf.rd_busy[0]), 64'd0);
`else
    checkOutput("x5_wbcyc_data", rfIf.rd_data[0], 64'd0);
    checkOutput("x5_wbcyc_busy", 64'(rfIf.rd_busy[0]), 64'd1);
`endif
    tick();
    idle();
    checkOutput("x5_data", rfIf.rd_data[0], 64'hDEAD_BEEF);
    checkOutput("x5_busy_after", 64'(rfIf.rd_busy[0]), 64'd0);
    checkOutput("x5_busy_cnt0", 64'(rfIf.busy_cnt), 64'd0);
    checkOutput("x5_err", 64'(rfIf.err_wb_idle), 64'd0);
    setRead(0, 1'b0, 5);
    idle();
    checkOutput("rd_en_off_data", rfIf.rd_data[0], 64'd0);

    // WAW on x7: blocked without wb, allowed with same-cycle wb
    setRead(1, 1'b1, 7);
    applyStimulus(1'b1, 7, 1'b0, 0, 64'h0, 1'b0);
    checkOutput("x7_first_ready", 64'(rfIf.iss_ready), 64'd1);
    tick();
    applyStimulus(1'b1, 7, 1'b0, 0, 64'h0, 1'b0);
    checkOutput("x7_waw_ready", 64'(rfIf.iss_ready), 64'd0);
    tick();
    applyStimulus(1'b1, 7, 1'b1, 7, 64'h77, 1'b0);
    checkOutput("x7_wb_ready", 64'(rfIf.iss_ready), 64'd1);
    checkOutput("x7_cnt_hold", 64'(rfIf.busy_cnt), 64'd1);
    tick();
    idle();
    checkOutput("x7_cnt_after", 64'(rfIf.busy_cnt), 64'd1);
    checkOutput("x7_still_busy", 64'(rfIf.rd_busy[1]), 64'd1);
    checkOutput("x7_data", rfIf.rd_data[1], 64'h77);
    checkOutput("x7_err", 64'(rfIf.err_wb_idle), 64'd0);
    applyStimulus(1'b0, 0, 1'b1, 7, 64'h78, 1'b0);
    tick();
    idle();
    checkOutput("x7_release_cnt", 64'(rfIf.busy_cnt), 64'd0);
    checkOutput("x7_data2", rfIf.rd_data[1], 64'h78);

    // x0: no write, no busy, no error
    setRead(0, 1'b1, 0);
    applyStimulus(1'b1, 0, 1'b1, 0, 64'h1, 1'b0);
    checkOutput("x0_iss_ready", 64'(rfIf.iss_ready), 64'd1);
    tick();
    idle();
    checkOutput("x0_data", rfIf.rd_data[0], 64'd0);
    checkOutput("x0_busy", 64'(rfIf.rd_busy[0]), 64'd0);
    checkOutput("x0_cnt", 64'(rfIf.busy_cnt), 64'd0);
    checkOutput("x0_err", 64'(rfIf.err_wb_idle), 64'd0);

    // Writeback to idle x3: data written, sticky error
    applyStimulus(1'b0, 0, 1'b1, 3, 64'h33, 1'b0);
    tick();
    setRead(0, 1'b1, 3);
    idle();
    checkOutput("x3_data", rfIf.rd_data[0], 64'h33);
    checkOutput("x3_err_set", 64'(rfIf.err_wb_idle), 64'd1);
    tick();
    idle();
    checkOutput("x3_err_sticky", 64'(rfIf.err_wb_idle), 64'd1);

    // Flush with x1..x4 busy, same-cycle wb x2 and issue x6
    for (int a = 1; a <= 4; a++) begin
      applyStimulus(1'b1, a, 1'b0, 0, 64'h0, 1'b0);
      tick();
    end
    idle();
    checkOutput("flush_pre_cnt", 64'(rfIf.busy_cnt), 64'd4);
    setRead(1, 1'b1, 2);
    applyStimulus(1'b1, 6, 1'b1, 2, 64'h22, 1'b1);
    tick();
    idle();
    checkOutput("flush_cnt", 64'(rfIf.busy_cnt), 64'd0);
    checkOutput("flush_x3_kept", rfIf.rd_data[0], 64'h33);
    checkOutput("flush_x3_busy", 64'(rfIf.rd_busy[0]), 64'd0);
    checkOutput("flush_x2_data", rfIf.rd_data[1], 64'h22);
    setRead(1, 1'b1, 6);
    idle();
    checkOutput("flush_x6_ignored", 64'(rfIf.rd_busy[1]), 64'd0);

    // Bypass behaviour on x9 (old value 0x11)
    applyStimulus(1'b0, 0, 1'b1, 9, 64'h11, 1'b0);
    tick();
    applyStimulus(1'b1, 9, 1'b0, 0, 64'h0, 1'b0);
    tick();
    setRead(1, 1'b1, 9);
    applyStimulus(1'b0, 0, 1'b1, 9, 64'h55, 1'b0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("x9_byp_data", rfIf.rd_data[1], 64'h55);
    checkOutput("x9_byp_busy", 64'(rfIf.rd_busy[1]), 64'd0);
`else
    checkOutput("x9_byp_data", rfIf.rd_data[1], 64'h11);
    checkOutput("x9_byp_busy", 64'(rfIf.rd_busy[1]), 64'd1);
`endif
    tick();
    idle();
    checkOutput("x9_data", rfIf.rd_data[1], 64'h55);
    checkOutput("x9_busy", 64'(rfIf.rd_busy[1]), 64'd0);

    // Asynchronous reset mid-operation with x10 busy
    applyStimulus(1'b1, 10, 1'b0, 0, 64'h0, 1'b0);
    tick();
    setRead(0, 1'b1, 10);
    setRead(1, 1'b1, 9);
    idle();
    checkOutput("x10_busy", 64'(rfIf.rd_busy[0]), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_cnt", 64'(rfIf.busy_cnt), 64'd0);
    checkOutput("arst_busy0", 64'(rfIf.rd_busy[0]), 64'd0);
    checkOutput("arst_x9_data", rfIf.rd_data[1], 64'd0);
    checkOutput("arst_err", 64'(rfIf.err_wb_idle), 64'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();
    idle();
    checkOutput("post_rst_cnt", 64'(rfIf.busy_cnt), 64'd0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
